// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rrdisp3_1_if.sv
// gf180mcu_fd_sc_mcu9t5v0__rrdisp3_1_if: source handshake, shared data bus and per-channel valid/accept for the dispatcher
interface gf180mcu_fd_sc_mcu9t5v0__rrdisp3_1_if #(
  parameter int WIDTH = 8
);
  logic             V;
  logic [WIDTH-1:0] D;
  logic             RDY;
  logic [WIDTH-1:0] Q;
  logic             Z1;
  logic             Z2;
  logic             Z3;
  logic             A1;
  logic             A2;
  logic             A3;
  logic             ERR;
  modport slave (
    input  V, D, A1, A2, A3,
    output RDY, Q, Z1, Z2, Z3, ERR
  );
  modport master (
    output V, D, A1, A2, A3,
    input  RDY, Q, Z1, Z2, Z3, ERR
  );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rrdisp3_1.sv
// gf180mcu_fd_sc_mcu9t5v0__rrdisp3_1: registered 1-to-3 round-robin dispatcher; GF180_RRDISP3_TIMEOUT_EN adds valid timeout redirect with sticky ERR
module gf180mcu_fd_sc_mcu9t5v0__rrdisp3_1 #(
  parameter int WIDTH = 8,
  parameter int TMO   = 15
) (
  input logic CLK,
  input logic RN,
  gf180mcu_fd_sc_mcu9t5v0__rrdisp3_1_if.slave bus
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t           st, st_n;
  logic [2:0]       z, z_n, a;
  logic [1:0]       ptr, ptr_n, k;
  logic [WIDTH-1:0] q, q_n;
  logic             drain, acc, to, err;
  if (WIDTH < 1 || TMO < 2) begin : g_bad_param
    $error("rrdisp3: WIDTH must be >= 1 and TMO >= 2");
  end
  function automatic logic [1:0] nx(input logic [1:0] p);
    return p == 2'b11 ? 2'b01 : p + 2'b01;
  endfunction
  function automatic logic [2:0] oh(input logic [1:0] p);
    return p == 2'b01 ? 3'b001 : p == 2'b10 ? 3'b010 : 3'b100;
  endfunction
  assign a       = {bus.A3, bus.A2, bus.A1};
  assign k       = z[0] ? 2'b01 : z[1] ? 2'b10 : 2'b11;
  assign drain   = |(z & a);
  assign bus.RDY = RN & ~to & (st == EMPTY | drain);
  assign acc     = bus.V & bus.RDY;
  assign bus.Q   = q;
  assign bus.Z1  = z[0];
  assign bus.Z2  = z[1];
  assign bus.Z3  = z[2];
  assign bus.ERR = err;
`ifdef GF180_RRDISP3_TIMEOUT_EN
  localparam int CW = $clog2(TMO);
  logic [CW-1:0] cnt, cnt_n;
  assign to = st == FULL && !drain && cnt == CW'(TMO - 1);
  // Age of the currently presented word; restarts on every load, drain or redirect
  always_comb cnt_n = (acc | drain | to) ? '0 : st == FULL ? cnt + 1'b1 : cnt;
  // Timeout counter and sticky error flag
  always_ff @(posedge CLK) begin
    if (!RN) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= cnt_n;
      err <= err | to;
    end
  end
`else
  assign to  = 1'b0;
  assign err = 1'b0;
`endif
  // Next state: a load wins over a drain, and a drain (acknowledge) wins over a timeout redirect
  always_comb begin
    st_n  = st;
    z_n   = z;
    q_n   = q;
    ptr_n = ptr;
    if (acc) begin
      q_n   = bus.D;
      z_n   = oh(ptr);
      ptr_n = nx(ptr);
      st_n  = FULL;
    end else if (drain) begin
      z_n   = 3'b000;
      st_n  = EMPTY;
    end else if (to) begin
      z_n   = oh(nx(k));
      ptr_n = nx(nx(k));
    end
  end
  // State, held word, channel valids and round-robin pointer
  always_ff @(posedge CLK) begin
    if (!RN) begin
      st  <= EMPTY;
      z   <= 3'b000;
      q   <= '0;
      ptr <= 2'b01;
    end else begin
      st  <= st_n;
      z   <= z_n;
      q   <= q_n;
      ptr <= ptr_n;
    end
  end
endmodule
